// File: rtl/serial_negator_pkg.sv
// rtl/serial_negator_pkg.sv - shared encodings and helpers for the serial negator
package serial_negator_pkg;

    // Operating modes; 2'b11 is reserved and behaves as pass-through.
    typedef enum logic [1:0] {
        OP_PASS = 2'b00,
        OP_NEG  = 2'b01,
        OP_ABS  = 2'b10,
        OP_RSVD = 2'b11
    } op_e;

    // Control FSM states.
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_BUSY = 2'b01,
        S_DONE = 2'b10
    } state_e;

    // Negation is "invert then add one", so the invert flag doubles as the
    // initial carry-in. Abs only inverts when the operand is negative.
    function automatic logic invert_flag(input logic [1:0] op, input logic sign);
        return (op == OP_NEG) || ((op == OP_ABS) && sign);
    endfunction

endpackage

// File: rtl/serial_negator_neg_chunk.sv
// rtl/serial_negator_neg_chunk.sv - one chunk of conditional invert plus carry increment
module neg_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] chunk,
    input  logic             inv,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout
);

    logic [CHUNK-1:0] opnd;

    // Conditionally complement the slice, then ripple the incoming carry through it.
    always_comb begin
        opnd        = inv ? ~chunk : chunk;
        {cout, sum} = {1'b0, opnd} + {{CHUNK{1'b0}}, cin};
    end

endmodule

// File: rtl/serial_negator.sv
// rtl/serial_negator.sv - multi-cycle two's-complement pass/negate/abs unit
module serial_negator
    import serial_negator_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] x,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic             zero
);

    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    if (((WIDTH % CHUNK) != 0) || (WIDTH < 2)) begin : g_param_check
        $error("serial_negator: WIDTH must be >= 2 and a multiple of CHUNK");
    end

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q;
    logic [WIDTH-1:0]  opnd_q;
    logic [WIDTH-1:0]  res_q, res_d;
    logic [WIDTH-1:0]  x_q;
    logic              carry_q;
    logic              inv_q;
    logic              ovf_q;
    logic              zero_q;

    logic              accept;
    logic              last;
    logic              inv_in;
    logic [CHUNK-1:0]  slice;
    logic [CHUNK-1:0]  sum;
    logic              cout;

    assign accept = (state_q == S_IDLE) && start;
    assign last   = (state_q == S_BUSY) && (cnt_q == LAST);
    assign inv_in = invert_flag(op, in[WIDTH-1]);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: start only counts in IDLE, DONE always returns to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_BUSY;
            S_BUSY:  if (last)  state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Status outputs decoded from the state.
    always_comb begin
        busy = (state_q != S_IDLE);
        done = (state_q == S_DONE);
    end

    // Select the operand chunk addressed by the chunk counter.
    always_comb begin
        slice = '0;
        for (int k = 0; k < N; k++) begin
            if (cnt_q == CW'(k)) begin
                slice = opnd_q[k*CHUNK +: CHUNK];
            end
        end
    end

    neg_chunk #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .chunk (slice),
        .inv   (inv_q),
        .cin   (carry_q),
        .sum   (sum),
        .cout  (cout)
    );

    // Merge the freshly computed chunk into the working result.
    always_comb begin
        res_d = res_q;
        for (int k = 0; k < N; k++) begin
            if (cnt_q == CW'(k)) begin
                res_d[k*CHUNK +: CHUNK] = sum;
            end
        end
    end

    // Datapath: capture on accept, step one chunk per BUSY cycle, publish on the last chunk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            opnd_q  <= '0;
            res_q   <= '0;
            x_q     <= '0;
            carry_q <= 1'b0;
            inv_q   <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else if (accept) begin
            opnd_q  <= in;
            inv_q   <= inv_in;
            carry_q <= inv_in;
            cnt_q   <= '0;
        end else if (state_q == S_BUSY) begin
            res_q   <= res_d;
            carry_q <= cout;
            if (last) begin
                cnt_q  <= '0;
                x_q    <= res_d;
                ovf_q  <= inv_q & opnd_q[WIDTH-1] & res_d[WIDTH-1];
                zero_q <= (res_d == '0);
            end else begin
                cnt_q  <= cnt_q + CW'(1);
            end
        end
    end

    assign x        = x_q;
    assign overflow = ovf_q;
    assign zero     = zero_q;

endmodule

// File: tb/tb_serial_negator.sv
// tb/tb_serial_negator.sv - self-checking bench for serial_negator
module tb_serial_negator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic       a_start, a_busy, a_done, a_ovf, a_zero;
    logic [1:0] a_op;
    logic [7:0] a_in, a_x;

    logic        b_start, b_busy, b_done, b_ovf, b_zero;
    logic [1:0]  b_op;
    logic [15:0] b_in, b_x;

    logic       c_start, c_busy, c_done, c_ovf, c_zero;
    logic [1:0] c_op;
    logic [7:0] c_in, c_x;

    serial_negator #(.WIDTH(8), .CHUNK(4)) u_a (
        .clk(clk), .rst_n(rst_n), .start(a_start), .op(a_op), .in(a_in),
        .x(a_x), .busy(a_busy), .done(a_done), .overflow(a_ovf), .zero(a_zero)
    );

    serial_negator #(.WIDTH(16), .CHUNK(4)) u_b (
        .clk(clk), .rst_n(rst_n), .start(b_start), .op(b_op), .in(b_in),
        .x(b_x), .busy(b_busy), .done(b_done), .overflow(b_ovf), .zero(b_zero)
    );

    serial_negator #(.WIDTH(8), .CHUNK(8)) u_c (
        .clk(clk), .rst_n(rst_n), .start(c_start), .op(c_op), .in(c_in),
        .x(c_x), .busy(c_busy), .done(c_done), .overflow(c_ovf), .zero(c_zero)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0] op;
        logic [7:0] in;
        logic [7:0] x;
        logic       ovf;
        logic       zero;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input int sel, input logic st, input logic [1:0] o, input logic [15:0] v);
        case (sel)
            0: begin a_start = st; a_op = o; a_in = v[7:0]; end
            1: begin b_start = st; b_op = o; b_in = v;      end
            default: begin c_start = st; c_op = o; c_in = v[7:0]; end
        endcase
    endtask

    // {busy, done, overflow, zero, x zero-extended to 16 bits}
    function automatic logic [19:0] outs(input int sel);
        case (sel)
            0:       return {a_busy, a_done, a_ovf, a_zero, 8'h00, a_x};
            1:       return {b_busy, b_done, b_ovf, b_zero, b_x};
            default: return {c_busy, c_done, c_ovf, c_zero, 8'h00, c_x};
        endcase
    endfunction

    function automatic logic [15:0] ref_x(input int w, input logic [1:0] o, input logic [15:0] v);
        logic [15:0] mask, vm, neg;
        logic        s;
        mask = (w == 16) ? 16'hFFFF : 16'h00FF;
        vm   = v & mask;
        neg  = (16'h0000 - vm) & mask;
        s    = (w == 16) ? vm[15] : vm[7];
        case (o)
            2'b01:   return neg;
            2'b10:   return s ? neg : vm;
            default: return vm;
        endcase
    endfunction

    function automatic logic ref_ovf(input int w, input logic [1:0] o, input logic [15:0] v);
        logic [15:0] mask, vm, minv;
        logic        s;
        mask = (w == 16) ? 16'hFFFF : 16'h00FF;
        minv = (w == 16) ? 16'h8000 : 16'h0080;
        vm   = v & mask;
        s    = (vm == minv);
        return ((o == 2'b01) || (o == 2'b10)) && s;
    endfunction

    task automatic run_op(input int sel, input int n, input logic [1:0] o, input logic [15:0] v,
                          input logic [15:0] ex, input logic eo, input logic ez, input string tag);
        logic [19:0] r;
        logic        early;
        @(negedge clk);
        drive(sel, 1'b1, o, v);
        @(posedge clk);
        #1;
        drive(sel, 1'b0, o, ~v);
        r = outs(sel);
        chk({tag, " busy_at_accept"}, {31'd0, r[19]}, 32'd1);
        early = 1'b0;
        for (int c = 1; c < n; c++) begin
            @(posedge clk);
            #1;
            r = outs(sel);
            if (r[18]) early = 1'b1;
        end
        chk({tag, " done_early"}, {31'd0, early}, 32'd0);
        @(posedge clk);
        #1;
        r = outs(sel);
        chk({tag, " done"}, {31'd0, r[18]}, 32'd1);
        chk({tag, " x"}, {16'd0, r[15:0]}, {16'd0, ex});
        chk({tag, " overflow"}, {31'd0, r[17]}, {31'd0, eo});
        chk({tag, " zero"}, {31'd0, r[16]}, {31'd0, ez});
        @(posedge clk);
        #1;
        r = outs(sel);
        chk({tag, " idle_after"}, {30'd0, r[19:18]}, 32'd0);
        chk({tag, " x_held"}, {16'd0, r[15:0]}, {16'd0, ex});
    endtask

    initial begin
        logic [19:0] r;
        logic [1:0]  o;
        logic [15:0] v, ex;
        int          pulses;
        logic [7:0]  xs;
        logic        seen;

        tbl[0]  = '{2'b01, 8'h05, 8'hFB, 1'b0, 1'b0};
        tbl[1]  = '{2'b01, 8'h80, 8'h80, 1'b1, 1'b0};
        tbl[2]  = '{2'b10, 8'h80, 8'h80, 1'b1, 1'b0};
        tbl[3]  = '{2'b10, 8'hF6, 8'h0A, 1'b0, 1'b0};
        tbl[4]  = '{2'b10, 8'h3C, 8'h3C, 1'b0, 1'b0};
        tbl[5]  = '{2'b00, 8'hA5, 8'hA5, 1'b0, 1'b0};
        tbl[6]  = '{2'b01, 8'h00, 8'h00, 1'b0, 1'b1};
        tbl[7]  = '{2'b11, 8'h80, 8'h80, 1'b0, 1'b0};
        tbl[8]  = '{2'b00, 8'h00, 8'h00, 1'b0, 1'b1};
        tbl[9]  = '{2'b01, 8'h01, 8'hFF, 1'b0, 1'b0};
        tbl[10] = '{2'b10, 8'hFF, 8'h01, 1'b0, 1'b0};

        rst_n = 1'b0;
        drive(0, 1'b0, 2'b00, 16'h0);
        drive(1, 1'b0, 2'b00, 16'h0);
        drive(2, 1'b0, 2'b00, 16'h0);
        #2;
        chk("reset_a", {12'd0, outs(0)}, 32'd0);
        chk("reset_b", {12'd0, outs(1)}, 32'd0);
        chk("reset_c", {12'd0, outs(2)}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            run_op(0, 2, tbl[i].op, {8'h00, tbl[i].in}, {8'h00, tbl[i].x},
                   tbl[i].ovf, tbl[i].zero, $sformatf("vec%0d", i));
        end

        // Start held high and operand changed during BUSY: captured operand wins, single done.
        @(negedge clk);
        drive(0, 1'b1, 2'b01, 16'h0005);
        @(posedge clk);
        #1;
        a_in   = 8'h77;
        pulses = 0;
        xs     = 8'h00;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            r = outs(0);
            if (r[18]) begin
                pulses++;
                xs      = r[7:0];
                a_start = 1'b0;
            end
        end
        a_start = 1'b0;
        chk("hold_start pulses", pulses, 32'd1);
        chk("hold_start x", {24'd0, xs}, 32'h0000_00FB);

        // Asynchronous reset in the middle of an operation.
        @(negedge clk);
        drive(0, 1'b1, 2'b10, 16'h00F6);
        @(posedge clk);
        #1;
        drive(0, 1'b0, 2'b00, 16'h0);
        r = outs(0);
        chk("mid_reset busy_before", {31'd0, r[19]}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_reset outs_immediate", {12'd0, outs(0)}, 32'd0);
        @(posedge clk);
        #1;
        chk("mid_reset outs_held", {12'd0, outs(0)}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            r = outs(0);
            if (r[18] || r[19]) seen = 1'b1;
        end
        chk("mid_reset no_done", {31'd0, seen}, 32'd0);
        run_op(0, 2, 2'b01, 16'h0005, 16'h00FB, 1'b0, 1'b0, "after_reset");

        // WIDTH=16 / CHUNK=4 sweep, corners first.
        run_op(1, 4, 2'b01, 16'h8000, 16'h8000, 1'b1, 1'b0, "w16 neg_min");
        run_op(1, 4, 2'b10, 16'h8000, 16'h8000, 1'b1, 1'b0, "w16 abs_min");
        run_op(1, 4, 2'b01, 16'h0000, 16'h0000, 1'b0, 1'b1, "w16 neg_zero");
        run_op(1, 4, 2'b01, 16'h0100, 16'hFF00, 1'b0, 1'b0, "w16 neg_0100");
        for (int i = 0; i < 24; i++) begin
            o  = 2'($urandom_range(0, 3));
            v  = 16'($urandom);
            ex = ref_x(16, o, v);
            run_op(1, 4, o, v, ex, ref_ovf(16, o, v), (ex == 16'h0),
                   $sformatf("w16 rnd%0d op%0d in%04h", i, o, v));
        end

        // WIDTH=8 / CHUNK=8 single-chunk sweep.
        run_op(2, 1, 2'b10, 16'h0080, 16'h0080, 1'b1, 1'b0, "w8c8 abs_min");
        run_op(2, 1, 2'b01, 16'h0000, 16'h0000, 1'b0, 1'b1, "w8c8 neg_zero");
        for (int i = 0; i < 16; i++) begin
            o  = 2'($urandom_range(0, 3));
            v  = {8'h00, 8'($urandom)};
            ex = ref_x(8, o, v);
            run_op(2, 1, o, v, ex, ref_ovf(8, o, v), (ex == 16'h0),
                   $sformatf("w8c8 rnd%0d op%0d in%02h", i, o, v[7:0]));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
